// File: rtl/bsg_cas_pkg.sv
// Shared types and helpers for the compare-and-swap restore block.
package bsg_cas_pkg;

  localparam int unsigned cas_width_lp     = 16;
  localparam int unsigned cas_els_lp       = 4;
  localparam int unsigned cas_ptr_width_lp = $clog2(cas_els_lp);

  // One element pair; lo is element 0.
  typedef struct packed {
    logic [cas_width_lp-1:0] hi;
    logic [cas_width_lp-1:0] lo;
  } cas_pair_t;

  // Exchange the two halves when flag is set.
  function automatic cas_pair_t cas_swap(cas_pair_t pair, logic flag);
    cas_pair_t res;
    res = pair;
    if (flag) begin
      res.hi = pair.lo;
      res.lo = pair.hi;
    end
    return res;
  endfunction

endpackage

// File: rtl/bsg_cas_flag_fifo.sv
// 1-bit swap-flag FIFO, els_p deep (power of 2). Count register separates full from empty.
module bsg_cas_flag_fifo #(
  parameter int unsigned els_p = 4
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic push_i,
  input  logic data_i,
  input  logic pop_i,
  output logic data_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

  logic [els_p-1:0]    mem_q, mem_d;
  logic [ptr_w_lp-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                push_v, pop_v;

  assign full_o  = (count_q == cnt_w_lp'(els_p));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rptr_q];

  // Illegal push/pop requests are ignored rather than corrupting state.
  assign push_v = push_i & ~full_o;
  assign pop_v  = pop_i & ~empty_o;

  // Next-state: pointers wrap naturally since els_p is a power of 2.
  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_v) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = wptr_q + ptr_w_lp'(1);
    end
    if (pop_v) begin
      rptr_d = rptr_q + ptr_w_lp'(1);
    end
    unique case ({push_v, pop_v})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/bsg_compare_and_swap_restore.sv
// Restores original element order of pairs returning from a compare-and-swap pipe.
// Optional CAS_RESTORE_BYPASS_EN: with the flag FIFO empty, a flag arriving together with its
// pair and free output space is applied directly and never enters the FIFO.
module bsg_compare_and_swap_restore
  import bsg_cas_pkg::*;
#(
  parameter int unsigned width_p = cas_width_lp,
  parameter int unsigned els_p   = cas_els_lp
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 rec_v_i,
  input  logic                 rec_swapped_i,
  output logic                 rec_ready_o,
  input  logic                 data_v_i,
  input  logic [2*width_p-1:0] data_i,
  output logic                 data_ready_o,
  output logic                 v_o,
  output logic [2*width_p-1:0] data_o,
  output logic                 swapped_o,
  input  logic                 yumi_i
);

  logic                 fifo_full, fifo_empty, fifo_head, fifo_push, fifo_pop;
  logic                 flag_avail, flag, out_space, accept;
  logic [2*width_p-1:0] restored;
  logic                 v_q, v_d, swapped_q, swapped_d;
  logic [2*width_p-1:0] data_q, data_d;

  assign out_space = ~v_q | yumi_i;

`ifdef CAS_RESTORE_BYPASS_EN
  logic bypass;
  assign bypass     = fifo_empty & rec_v_i & data_v_i & out_space;
  assign flag_avail = ~fifo_empty | bypass;
  assign flag       = fifo_empty ? rec_swapped_i : fifo_head;
  assign fifo_push  = rec_v_i & ~fifo_full & ~bypass;
`else
  assign flag_avail = ~fifo_empty;
  assign flag       = fifo_head;
  assign fifo_push  = rec_v_i & ~fifo_full;
`endif

  // Flag acceptance never depends on a same-cycle pop.
  assign rec_ready_o  = ~fifo_full;
  assign data_ready_o = flag_avail & out_space;
  assign accept       = data_v_i & data_ready_o;
  assign fifo_pop     = accept & ~fifo_empty;

  bsg_cas_flag_fifo #(
    .els_p(els_p)
  ) u_flag_fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .push_i   (fifo_push),
    .data_i   (rec_swapped_i),
    .pop_i    (fifo_pop),
    .data_o   (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // Un-swap mux; the packed pair type only fits the default element width.
  if (width_p == cas_width_lp) begin : g_pkg_swap
    assign restored = cas_swap(cas_pair_t'(data_i), flag);
  end else begin : g_gen_swap
    assign restored = flag ? {data_i[width_p-1:0], data_i[2*width_p-1:width_p]} : data_i;
  end

  // Output register: hold while stalled, reload on accept, clear on yumi.
  always_comb begin
    v_d       = v_q;
    data_d    = data_q;
    swapped_d = swapped_q;
    if (yumi_i) begin
      v_d = 1'b0;
    end
    if (accept) begin
      v_d       = 1'b1;
      data_d    = restored;
      swapped_d = flag;
    end
  end

  // Output state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      v_q       <= 1'b0;
      data_q    <= '0;
      swapped_q <= 1'b0;
    end else begin
      v_q       <= v_d;
      data_q    <= data_d;
      swapped_q <= swapped_d;
    end
  end

  assign v_o       = v_q;
  assign data_o    = data_q;
  assign swapped_o = swapped_q;

endmodule

// File: tb/tb_bsg_compare_and_swap_restore.sv
// Scoreboard bench for bsg_compare_and_swap_restore (width_p = 16, els_p = 4).
// Honours CAS_RESTORE_BYPASS_EN when defined for both DUT and bench.
module tb_bsg_compare_and_swap_restore;

  localparam int unsigned W   = 16;
  localparam int unsigned ELS = 4;

  logic            clk = 1'b0;
  logic            reset_n_i;
  logic            rec_v_i, rec_swapped_i, rec_ready_o;
  logic            data_v_i, data_ready_o;
  logic [2*W-1:0]  data_i, data_o;
  logic            v_o, swapped_o, yumi_i;

  always #5 clk = ~clk;

  bsg_compare_and_swap_restore #(
    .width_p(W),
    .els_p  (ELS)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n_i),
    .rec_v_i      (rec_v_i),
    .rec_swapped_i(rec_swapped_i),
    .rec_ready_o  (rec_ready_o),
    .data_v_i     (data_v_i),
    .data_i       (data_i),
    .data_ready_o (data_ready_o),
    .v_o          (v_o),
    .data_o       (data_o),
    .swapped_o    (swapped_o),
    .yumi_i       (yumi_i)
  );

  int          checks   = 0;
  int          errors   = 0;
  int          out_cnt  = 0;  // pairs presented or pending at the output, per the model
  int          consumed = 0;
  bit          mon_en   = 1'b0;
  logic [32:0] exp_q[$];      // {swapped, data} in output order
  logic        flag_q[$];     // flags accepted but not yet applied

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] restore(input logic [31:0] p, input logic f);
    return f ? {p[15:0], p[31:16]} : p;
  endfunction

  // Monitor: registered outputs against the scoreboard head, popping on yumi.
  always @(posedge clk) begin
    #2;
    if (mon_en) begin
      check("v_o", 64'(v_o), 64'(exp_q.size() > 0));
      if (v_o && exp_q.size() > 0) begin
        check("out_pair", 64'({swapped_o, data_o}), 64'(exp_q[0]));
        if (yumi_i) begin
          void'(exp_q.pop_front());
          consumed++;
        end
      end
    end
  end

  // One clock of stimulus; checks the ready outputs and advances the reference model.
  task automatic cycle(input logic rv, input logic rs, input logic dv, input logic [31:0] d,
                       input logic y, output logic r_acc, output logic d_acc);
    logic y_eff, exp_rr, exp_dr, space, fl;
    @(posedge clk);
    #1;
    y_eff         = y && (out_cnt > 0);
    rec_v_i       = rv;
    rec_swapped_i = rs;
    data_v_i      = dv;
    data_i        = d;
    yumi_i        = y_eff;
    #3;
    space  = (out_cnt == 0) || y_eff;
    exp_rr = flag_q.size() < ELS;
    exp_dr = (flag_q.size() > 0) && space;
`ifdef CAS_RESTORE_BYPASS_EN
    if (flag_q.size() == 0 && rv && dv && space) exp_dr = 1'b1;
`endif
    check("rec_ready_o", 64'(rec_ready_o), 64'(exp_rr));
    check("data_ready_o", 64'(data_ready_o), 64'(exp_dr));
    r_acc = rv & rec_ready_o;
    d_acc = dv & data_ready_o;
    if (rv && exp_rr) flag_q.push_back(rs);
    if (dv && exp_dr) begin
      fl = flag_q.pop_front();
      exp_q.push_back({fl, restore(d, fl)});
    end
    out_cnt = out_cnt - (y_eff ? 1 : 0) + ((dv && exp_dr) ? 1 : 0);
  endtask

  task automatic drain();
    logic ra, da;
    int   n = 0;
    while (out_cnt > 0 && n < 16) begin
      cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, ra, da);
      n++;
    end
    check("drain", 64'(out_cnt), 64'd0);
  endtask

  task automatic flush();
    logic ra, da;
    int   n = 0;
    while (flag_q.size() > 0 && n < 32) begin
      cycle(1'b0, 1'b0, 1'b1, $urandom, 1'b1, ra, da);
      n++;
    end
    check("flush", 64'(flag_q.size()), 64'd0);
    drain();
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    reset_n_i = 1'b0;
    rec_v_i   = 1'b0;
    data_v_i  = 1'b0;
    yumi_i    = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    flag_q.delete();
    exp_q.delete();
    out_cnt = 0;
    check("rst_v_o", 64'(v_o), 64'd0);
    check("rst_rec_ready", 64'(rec_ready_o), 64'd1);
    check("rst_data_ready", 64'(data_ready_o), 64'd0);
    reset_n_i = 1'b1;
    mon_en    = 1'b1;
  endtask

  initial begin : stim
    logic        ra, da, rv_pend, dv_pend, rs_cur;
    logic [31:0] d_cur;
    int          acc, guard, base;
    bit          did_reset;

    // Reset with random inputs, then idle inputs while still in reset.
    reset_n_i = 1'b0;
    rec_v_i = 1'b0; rec_swapped_i = 1'b0; data_v_i = 1'b0; data_i = '0; yumi_i = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      rec_v_i       = 1'($urandom_range(0, 1));
      rec_swapped_i = 1'($urandom_range(0, 1));
      data_v_i      = 1'($urandom_range(0, 1));
      data_i        = $urandom;
      yumi_i        = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    rec_v_i = 1'b0; data_v_i = 1'b0; yumi_i = 1'b0;
    #3;
    check("reset_v_o", 64'(v_o), 64'd0);
    check("reset_rec_ready", 64'(rec_ready_o), 64'd1);
    check("reset_data_ready", 64'(data_ready_o), 64'd0);
    check("reset_data_o", 64'(data_o), 64'd0);
    check("reset_swapped_o", 64'(swapped_o), 64'd0);
    @(posedge clk);
    #1;
    reset_n_i = 1'b1;
    mon_en    = 1'b1;

    // Order restore.
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, ra, da);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, ra, da);
    cycle(1'b0, 1'b0, 1'b1, 32'hBBBB_AAAA, 1'b1, ra, da);
    check("restore_acc1", 64'(da), 64'd1);
    cycle(1'b0, 1'b0, 1'b1, 32'h2222_1111, 1'b1, ra, da);
    check("restore_acc2", 64'(da), 64'd1);
    check("restore_data1", 64'(data_o), 64'h0000_0000_AAAA_BBBB);
    check("restore_swap1", 64'(swapped_o), 64'd1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, ra, da);
    check("restore_data2", 64'(data_o), 64'h0000_0000_2222_1111);
    check("restore_swap2", 64'(swapped_o), 64'd0);
    drain();

    // Full FIFO holds off the fifth flag until a pair drains one.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'(i), 1'b0, 32'h0, 1'b0, ra, da);
      check("full_push", 64'(ra), 64'd1);
    end
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, ra, da);
    check("full_hold", 64'(ra), 64'd0);
    cycle(1'b1, 1'b1, 1'b1, 32'h1357_9BDF, 1'b1, ra, da);
    check("full_pair_acc", 64'(da), 64'd1);
    check("full_no_same_cycle", 64'(ra), 64'd0);
    cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, ra, da);
    check("full_fifth_acc", 64'(ra), 64'd1);
    flush();

    // Data before flag.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b1, ra, da);
      check("early_data_stall", 64'(da), 64'd0);
    end
    cycle(1'b1, 1'b1, 1'b1, 32'h1234_5678, 1'b1, ra, da);
`ifdef CAS_RESTORE_BYPASS_EN
    check("bypass_acc_c6", 64'(da), 64'd1);
`else
    check("nobypass_c6", 64'(da), 64'd0);
    cycle(1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b1, ra, da);
    check("nobypass_acc_c7", 64'(da), 64'd1);
`endif
    drain();

    // Backpressure during a 6-pair stream.
    base = consumed;
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'($urandom), 1'b0, 32'h0, 1'b0, ra, da);
    rv_pend = 1'b1; rs_cur = 1'($urandom);
    for (int i = 0; i < 2; i++) begin
      cycle(rv_pend, rs_cur, 1'b1, $urandom, 1'b1, ra, da);
      check("bp_stream", 64'(da), 64'd1);
      if (ra) rs_cur = 1'($urandom);
    end
    d_cur = $urandom;
    for (int i = 0; i < 4; i++) begin
      cycle(rv_pend, rs_cur, 1'b1, d_cur, 1'b0, ra, da);
      check("bp_hold", 64'(da), 64'd0);
      if (ra) rs_cur = 1'($urandom);
    end
    for (int i = 0; i < 4; i++) begin
      cycle(rv_pend, rs_cur, 1'b1, d_cur, 1'b1, ra, da);
      check("bp_resume", 64'(da), 64'd1);
      if (ra) rs_cur = 1'($urandom);
      d_cur = $urandom;
    end
    drain();
    check("bp_no_loss", 64'(consumed - base), 64'd6);
    flush();

    // Random stream with wraparound and a mid-stream reset.
    acc = 0; guard = 0; did_reset = 1'b0;
    rv_pend = 1'b0; dv_pend = 1'b0; rs_cur = 1'b0; d_cur = '0;
    while (acc < 20 && guard < 600) begin
      if (acc == 10 && !did_reset) begin
        did_reset = 1'b1;
        do_reset();
        rv_pend = 1'b0;
        dv_pend = 1'b0;
        cycle(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, ra, da);
        cycle(1'b0, 1'b0, 1'b1, 32'hCAFE_0001, 1'b1, ra, da);
        check("post_reset_acc", 64'(da), 64'd1);
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, ra, da);
        check("post_reset_data", 64'(data_o), 64'h0000_0000_0001_CAFE);
        check("post_reset_swap", 64'(swapped_o), 64'd1);
      end
      if (!rv_pend && $urandom_range(0, 1) == 1) begin
        rv_pend = 1'b1;
        rs_cur  = 1'($urandom_range(0, 1));
      end
      if (!dv_pend && $urandom_range(0, 2) != 0) begin
        dv_pend = 1'b1;
        d_cur   = $urandom;
      end
      cycle(rv_pend, rs_cur, dv_pend, d_cur, 1'($urandom_range(0, 3) != 0), ra, da);
      if (ra) rv_pend = 1'b0;
      if (da) begin
        dv_pend = 1'b0;
        acc++;
      end
      guard++;
    end
    check("random_pairs_done", 64'(acc >= 20), 64'd1);
    flush();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
